instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/isa_pkg.sv | 28 ++
 rtl/instr_fetch_if.sv | 17 +
 rtl/fetch_fsm.sv | 48 ++++
 rtl/instr_fetch.sv | 67 ++++++
 tb/tb_instr_fetch.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch and decode stages.
// Contents: address/instruction widths, opcode map, fetch FSM state encoding.
package isa_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    // Instruction format: [15:12] opcode, [11:10] rs, [9:8] rt, [7:6] rd / [7:0] imm
    localparam logic [3:0] OP_LW   = 4'd0;
    localparam logic [3:0] OP_SW   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_CLR  = 4'd13;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] S_FILL = 1'b0;
    localparam logic [STATE_W-1:0] S_RUN  = 1'b1;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage and a synchronous RAM.
// Signals:
//   imem_addr  - read address (fetch -> memory)
//   imem_en    - read enable (fetch -> memory); memory holds rdata while low
//   imem_rdata - word for the address sampled at the previous enabled edge
// Modports: master = fetch stage, slave = memory.
interface instr_fetch_if #(
    parameter int PC_W    = isa_pkg::PC_W,
    parameter int INSTR_W = isa_pkg::INSTR_W
);
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, output imem_en, input  imem_rdata);
    modport slave  (input  imem_addr, input  imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_fsm.sv
// Fetch sequencing: state and next-PC logic.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   stall          - hold request; freezes all state
//   branch_taken   - redirect request (overrides stall)
//   branch_target  - redirect address
//   fetch_pc       - address currently presented to the memory
//   pending_pc     - address of the word arriving on imem_rdata
//   load           - the data path captures imem_rdata this edge
//
// state  | meaning
// S_FILL | imem_rdata not yet valid for any address we want
// S_RUN  | imem_rdata holds mem[pending_pc]
module fetch_fsm #(
    parameter int PC_W = isa_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] fetch_pc,
    output logic [PC_W-1:0] pending_pc,
    output logic            load
);
    import isa_pkg::*;

    logic [STATE_W-1:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= '0;
            pending_pc <= '0;
            state      <= S_FILL;
        end else if (branch_taken) begin
            // The word already in flight belongs to the old stream; refill.
            fetch_pc <= branch_target;
            state    <= S_FILL;
        end else if (!stall) begin
            pending_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + 1'b1;   // wraps modulo 2^PC_W
            state      <= S_RUN;
        end
    end

    assign load = (state == S_RUN) && !stall && !branch_taken;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and hands
// registered instruction words to the decoder, with stall and branch redirect.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall           - downstream hold request
//   branch_taken    - redirect request; wins over stall
//   branch_target   - redirect address
//   imem            - instruction-memory read port (master side)
//   instr           - instruction word to the decoder, 0 when not valid
//   instr_valid     - instr holds a real instruction
//   pc_out          - address of the word in instr
//   fetch_count     - saturating count of delivered instructions
module instr_fetch #(
    parameter int PC_W    = isa_pkg::PC_W,
    parameter int INSTR_W = isa_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    instr_fetch_if.master      imem,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic [15:0]        fetch_count
);
    import isa_pkg::*;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] pending_pc;
    logic            load;

    fetch_fsm #(.PC_W(PC_W)) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc),
        .pending_pc    (pending_pc),
        .load          (load)
    );

    // A redirect must sample the target even when stalled.
    assign imem.imem_addr = fetch_pc;
    assign imem.imem_en   = !stall || branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            fetch_count <= '0;
        end else if (branch_taken) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= imem.imem_rdata;
            pc_out      <= pending_pc;
            instr_valid <= 1'b1;
            if (fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import isa_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc_out;
    logic [15:0]   fetch_count;

    instr_fetch_if #(.PC_W(AW), .INSTR_W(DW)) imem ();

    instr_fetch #(.PC_W(AW), .INSTR_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (imem.imem_en)
            imem.imem_rdata <= mem[imem.imem_addr];
    end

    // Reference model: one warm-up cycle after (re)start, then one word per
    // unstalled cycle from a sequential address stream.
    typedef struct {
        logic          valid;
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
        logic [15:0]   cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic          m_valid;
    logic [DW-1:0] m_instr;
    logic [AW-1:0] m_pc;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_next;
    logic          m_warm;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
        if (r) begin
            m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt = '0;
            m_next  = '0;   m_warm  = 1'b0;
        end else if (b) begin
            m_valid = 1'b0; m_instr = '0;
            m_next  = t;    m_warm  = 1'b0;
        end else if (!s) begin
            if (m_warm) begin
                m_valid = 1'b1;
                m_instr = mem[m_next];
                m_pc    = m_next;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_next  = m_next + 8'd1;
            end else begin
                m_warm = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
        exp_t e;
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge(r, s, b, t);
        e.valid = m_valid; e.instr = m_instr; e.pc = m_pc; e.cnt = m_cnt;
        q.push_back(e);
        #1;
    endtask

    task automatic run_until_pc(input logic [AW-1:0] pc, input int budget);
        int n;
        n = 0;
        while (!(m_valid && m_pc == pc) && n < budget) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        if (!(m_valid && m_pc == pc)) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_until_pc: pc %h not reached within %0d cycles", pc, budget);
        end
    endtask

    // Monitor: compares DUT outputs against the model once per cycle
    always @(negedge clk) begin
        check("imem_en", 32'(imem.imem_en), 32'((!stall) | branch_taken));
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("instr_valid", 32'(instr_valid), 32'(mon_e.valid));
            check("instr",       32'(instr),       32'(mon_e.instr));
            check("fetch_count", 32'(fetch_count), 32'(mon_e.cnt));
            if (mon_e.valid)
                check("pc_out", 32'(pc_out), 32'(mon_e.pc));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2540;
        mem[1] = 16'h3105;
        mem[7] = {OP_BEQ, 2'd1, 2'd2, 8'h18};

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt = '0; m_next = '0; m_warm = 1'b0;

        // Reset, then first words mem[0], mem[1]
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        run_until_pc(8'h04, 20);

        // Stall while mem[4] is held
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        run_until_pc(8'h07, 20);

        // Branch from BEQ at pc 7 to 0x20
        step(1'b0, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        // Branch together with stall, then run across the 0xFF -> 0x00 wrap
        step(1'b0, 1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        // Random mix of stall, branch and reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 6),
                 8'($urandom));
        end

        // Run long enough to saturate fetch_count, then reset mid-stream at pc 0x12
        for (int i = 0; i < 65600; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        run_until_pc(8'h12, 300);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
